ring_buffer_writer: RTL and testbench
=====================================

// Module: ring_buffer_writer
// PURPOSE
//  Producer stage of the shared-memory command ring. Accepts 32-bit command words over a
//  valid/ready stream and writes each one into the next free ring slot in memory. After
//  each write it publishes the new write pointer at address 0x0002, where the downstream
//  ring reader polls it. The block polls the reader's pointer at 0x0001 to detect full.
// PARAMETERS
//  RING_BASE   15'h0010  memory address of ring slot 0; slot i is at RING_BASE+i
//  PTR_W       4         pointer width; ring depth = 2**PTR_W = 16 slots
//  POLL_GAP    8         idle cycles between read-pointer re-polls while the ring is full
// PORTS
//  clk            in   1   system clock, all logic on rising edge
//  rst            in   1   asynchronous, active-high reset
//  in_valid       in   1   upstream command word valid
//  in_data        in   32  upstream command word
//  in_ready       out  1   block can accept a word this cycle
//  mem_DataOut    in   32  memory read data; valid in the cycle mem_done=1
//  mem_done       in   1   single-cycle pulse: current access complete
//  mem_enable     out  1   access request; held high until mem_done
//  mem_readWrite  out  1   1=read, 0=write
//  mem_address    out  15  access address
//  mem_DataWrite  out  32  write data
//  ring_full      out  1   high while stalled on a full ring
//  words_written  out  16  count of words committed (pointer published), wraps at 2**16
// BEHAVIOUR
//  Reset: all outputs 0 (in_ready=0, mem_enable=0, mem_readWrite=0, mem_address=0,
//   mem_DataWrite=0, ring_full=0, words_written=0); wp=0, rp_cache=0; state=S_INIT.
//   Reset mid-access drops mem_enable immediately. The in-flight word is lost.
//  Memory handshake: address, readWrite and data are set in the cycle mem_enable rises and
//   stay stable until mem_done. mem_enable falls the cycle after mem_done. It then stays
//   low for at least 1 cycle before the next request. mem_done while mem_enable=0 is ignored.
//  Full rule: ring is full iff ((wp+1) mod 2**PTR_W) == rp. One slot always stays empty.
//   Empty (wp==rp) is the reader's concern.
//  States:
//   S_INIT      write 0 to 0x0002 (publish wp=0); on done -> S_IDLE
//   S_IDLE      in_ready=1; on in_valid&in_ready latch in_data, in_ready->0 next cycle;
//               -> S_CHECK if cached rp shows not full, else -> S_RD_RP
//   S_RD_RP     read 0x0001; on done rp_cache<=mem_DataOut[PTR_W-1:0] -> S_CHECK
//   S_CHECK     full -> S_BACKOFF, ring_full=1; else ring_full=0 -> S_WR_DATA
//   S_BACKOFF   count POLL_GAP cycles -> S_RD_RP
//   S_WR_DATA   write latched word to RING_BASE+wp; on done -> S_WR_WP
//   S_WR_WP     write zero-extended (wp+1) to 0x0002; on done wp<=wp+1,
//               words_written+=1 -> S_IDLE
//  The pointer publish always follows the data write completion, never precedes it,
//   so the reader never sees an unwritten slot.
//  wp wraps 15->0 (PTR_W bits). Slot address = RING_BASE + wp, computed in 15 bits.
//  Only one word is in flight. Minimum accept-to-accept latency = 2 accesses + gaps.
//  in_ready is high only in S_IDLE.
// STRUCTURE
//  Package ring_pkg: ADDR_RD_PTR=15'h0001, ADDR_WR_PTR=15'h0002, RING_BASE, PTR_W,
//   state encoding, and mem_readWrite encodings (MEM_READ=1, MEM_WRITE=0). The downstream
//   ring reader shares this package.
//  One sub-module, mem_req_seq: owns the enable/done handshake and enforces the 1-cycle
//   low gap. The FSM drives it with start/addr/rw/wdata inputs and gets done/rdata back.
// TESTING
//  Memory model: mem_done 3 cycles after mem_enable rises; rp location preloaded.
//  1 Reset release -> first access is a write of 0 to 0x0002; in_ready rises after its done.
//  2 rp=0, push 0xDEADBEEF -> write 0xDEADBEEF @0x0010, then write 1 @0x0002;
//    words_written=1.
//  3 rp=0, push 15 words -> slots 0x0010..0x001E written, wp=15. The 16th word polls
//    0x0001 every POLL_GAP cycles with ring_full=1. Setting rp=3 -> the word is written
//    @0x001F, then 0 is published @0x0002 (wrap).
//  4 Stall, then mem_done held 0 for 50 cycles -> mem_enable, address and data stay
//    stable throughout; exactly one access per mem_done pulse.
//  5 Assert rst during S_WR_DATA -> mem_enable=0 the same cycle. After release: S_INIT
//    rewrite of 0 @0x0002 and words_written=0.
//  6 in_valid held high with back-to-back data -> each word accepted exactly once, in order.
//    Check the ordering mem_data_write_done < ptr_publish for every word.

Source files
------------

// File: rtl/ring_pkg.sv
// Shared definitions for the command ring producer and reader: fixed pointer
// addresses, ring geometry, state encoding and memory access encodings.
package ring_pkg;

  localparam int          PTR_W       = 4;
  localparam logic [14:0] RING_BASE   = 15'h0010;
  localparam int          POLL_GAP    = 8;

  localparam logic [14:0] ADDR_RD_PTR = 15'h0001;
  localparam logic [14:0] ADDR_WR_PTR = 15'h0002;

  localparam logic        MEM_READ    = 1'b1;
  localparam logic        MEM_WRITE   = 1'b0;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_RD_RP,
    S_CHECK,
    S_BACKOFF,
    S_WR_DATA,
    S_WR_WP
  } rbw_state_t;

  // Slot address arithmetic stays in the 15-bit memory address space.
  function automatic logic [14:0] slot_addr(input logic [14:0] base, input logic [14:0] idx);
    return base + idx;
  endfunction

endpackage

// File: rtl/mem_req_seq.sv
// Memory request sequencer: owns the enable/done handshake. A new request is
// only taken while enable is low, so enable always rests low for a cycle.
module mem_req_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [14:0] addr,
  input  logic        rw,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  input  logic [31:0] mem_DataOut,
  input  logic        mem_done,
  output logic        mem_enable,
  output logic        mem_readWrite,
  output logic [14:0] mem_address,
  output logic [31:0] mem_DataWrite
);
  import ring_pkg::*;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_enable    <= 1'b0;
      mem_readWrite <= MEM_WRITE;
      mem_address   <= '0;
      mem_DataWrite <= '0;
    end else if (mem_enable) begin
      if (mem_done) mem_enable <= 1'b0;
    end else if (start) begin
      mem_enable    <= 1'b1;
      mem_readWrite <= rw;
      mem_address   <= addr;
      mem_DataWrite <= wdata;
    end
  end

  // Stray done pulses outside an access are masked here.
  assign done  = mem_enable & mem_done;
  assign rdata = mem_DataOut;

endmodule

// File: rtl/ring_buffer_writer.sv
// Producer stage of the shared-memory command ring: writes each accepted word
// into the next free slot, then publishes the advanced write pointer.
//
// state     | meaning
// S_INIT    | publish wp=0 at the write-pointer location
// S_IDLE    | in_ready high, wait for a command word
// S_RD_RP   | fetch the reader's pointer into rp_cache
// S_CHECK   | decide full (back off) or free (write slot)
// S_BACKOFF | wait POLL_GAP cycles before re-polling the reader pointer
// S_WR_DATA | write the latched word to RING_BASE+wp
// S_WR_WP   | publish wp+1; commit pointer and word count on done
module ring_buffer_writer #(
  parameter logic [14:0] RING_BASE = ring_pkg::RING_BASE,
  parameter int          PTR_W     = ring_pkg::PTR_W,
  parameter int          POLL_GAP  = ring_pkg::POLL_GAP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  input  logic [31:0] mem_DataOut,
  input  logic        mem_done,
  output logic        mem_enable,
  output logic        mem_readWrite,
  output logic [14:0] mem_address,
  output logic [31:0] mem_DataWrite,
  output logic        ring_full,
  output logic [15:0] words_written
);
  import ring_pkg::*;

  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  rbw_state_t       state, state_nxt;
  logic [PTR_W-1:0] wp, wp_inc, rp_cache;
  logic [31:0]      data_q;
  logic [GAP_W-1:0] gap_cnt;
  logic             full;

  logic             seq_start, seq_rw, seq_done;
  logic [14:0]      seq_addr;
  logic [31:0]      seq_wdata, seq_rdata;
  logic             unused_rdata;

  assign wp_inc       = wp + 1'b1;
  assign full         = (wp_inc == rp_cache);
  assign in_ready     = (state == S_IDLE);
  assign unused_rdata = ^seq_rdata[31:PTR_W];

  mem_req_seq u_seq (
    .clk           (clk),
    .rst           (rst),
    .start         (seq_start),
    .addr          (seq_addr),
    .rw            (seq_rw),
    .wdata         (seq_wdata),
    .done          (seq_done),
    .rdata         (seq_rdata),
    .mem_DataOut   (mem_DataOut),
    .mem_done      (mem_done),
    .mem_enable    (mem_enable),
    .mem_readWrite (mem_readWrite),
    .mem_address   (mem_address),
    .mem_DataWrite (mem_DataWrite)
  );

  always_comb begin
    state_nxt = state;
    seq_start = 1'b0;
    seq_addr  = ADDR_WR_PTR;
    seq_rw    = MEM_WRITE;
    seq_wdata = '0;
    case (state)
      S_INIT: begin
        seq_start = 1'b1;
        if (seq_done) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (in_valid) state_nxt = full ? S_RD_RP : S_CHECK;
      end
      S_RD_RP: begin
        seq_start = 1'b1;
        seq_addr  = ADDR_RD_PTR;
        seq_rw    = MEM_READ;
        if (seq_done) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        state_nxt = full ? S_BACKOFF : S_WR_DATA;
      end
      S_BACKOFF: begin
        if (gap_cnt == '0) state_nxt = S_RD_RP;
      end
      S_WR_DATA: begin
        seq_start = 1'b1;
        seq_addr  = slot_addr(RING_BASE, 15'(wp));
        seq_wdata = data_q;
        if (seq_done) state_nxt = S_WR_WP;
      end
      S_WR_WP: begin
        // Pointer publish only starts after the slot write has completed.
        seq_start = 1'b1;
        seq_wdata = 32'(wp_inc);
        if (seq_done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_INIT;
      wp            <= '0;
      rp_cache      <= '0;
      data_q        <= '0;
      gap_cnt       <= '0;
      ring_full     <= 1'b0;
      words_written <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE:    if (in_valid) data_q <= in_data;
        S_RD_RP:   if (seq_done) rp_cache <= seq_rdata[PTR_W-1:0];
        S_CHECK: begin
          ring_full <= full;
          if (full) gap_cnt <= GAP_W'(POLL_GAP - 1);
        end
        S_BACKOFF: if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
        S_WR_WP: begin
          if (seq_done) begin
            wp            <= wp_inc;
            words_written <= words_written + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ring_buffer_writer.sv
// Directed bench for ring_buffer_writer with a 3-cycle-latency memory responder
// and an access log checked against hand-computed access sequences.
module tb_ring_buffer_writer;
  import ring_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [31:0] mem_DataOut;
  logic        mem_done;
  logic        mem_enable;
  logic        mem_readWrite;
  logic [14:0] mem_address;
  logic [31:0] mem_DataWrite;
  logic        ring_full;
  logic [15:0] words_written;

  ring_buffer_writer dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .mem_DataOut   (mem_DataOut),
    .mem_done      (mem_done),
    .mem_enable    (mem_enable),
    .mem_readWrite (mem_readWrite),
    .mem_address   (mem_address),
    .mem_DataWrite (mem_DataWrite),
    .ring_full     (ring_full),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [14:0] addr;
    logic [31:0] data;
    int          cyc;
  } acc_t;

  acc_t        log_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          prot_err = 0;
  int          cyc = 0;
  int          cnt = 0;
  logic        stall = 1'b0;
  logic [31:0] rp_val = 32'h0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory responder plus handshake monitor, evaluated on the falling edge.
  task automatic mem_model();
    logic        prev_en = 1'b0;
    logic [47:0] prev_sig = '0;
    logic [47:0] sig;
    acc_t        e;
    forever begin
      @(negedge clk);
      cyc++;
      sig = {mem_readWrite, mem_address, mem_DataWrite};
      if (mem_enable && prev_en && sig != prev_sig) prot_err++;
      if (mem_done) begin
        if (mem_enable !== 1'b0) prot_err++;
        mem_done = 1'b0;
      end else if (rst || !mem_enable) begin
        cnt = 0;
      end else if (!stall) begin
        cnt++;
        if (cnt == 3) begin
          cnt         = 0;
          mem_done    = 1'b1;
          mem_DataOut = (mem_address == ADDR_RD_PTR) ? rp_val : 32'h0;
          e.rw   = mem_readWrite;
          e.addr = mem_address;
          e.data = mem_readWrite ? mem_DataOut : mem_DataWrite;
          e.cyc  = cyc;
          log_q.push_back(e);
        end
      end
      prev_en  = mem_enable;
      prev_sig = sig;
    end
  endtask

  task automatic expect_acc(input string tag, input logic rw, input logic [14:0] addr,
                            input logic [31:0] data, output int t);
    acc_t e;
    for (int k = 0; k < 3000 && log_q.size() == 0; k++) @(negedge clk);
    check_val({tag, "_seen"}, (log_q.size() != 0), 1);
    t = -1;
    if (log_q.size() != 0) begin
      e = log_q.pop_front();
      t = e.cyc;
      check_val(tag, {e.rw, e.addr, e.data}, {rw, addr, data});
    end
  endtask

  task automatic wait_ready(input string tag);
    for (int k = 0; k < 3000 && !in_ready; k++) @(negedge clk);
    check_val(tag, in_ready, 1);
  endtask

  task automatic push(input logic [31:0] d);
    bit ok = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    for (int k = 0; k < 3000; k++) begin
      if (in_ready) begin
        @(posedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    check_val("push_acc", ok, 1);
    #1 in_valid = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int          t, t1, t2, td, tp;
    logic [31:0] d[5];
    logic [47:0] sig;
    bit          changed, dropped, seen;

    rst         = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    mem_done    = 1'b0;
    mem_DataOut = '0;
    fork
      mem_model();
    join_none

    // 1: reset values, then the initial pointer publish
    repeat (3) @(negedge clk);
    check_val("rst_ctl", {in_ready, mem_enable, mem_readWrite, ring_full, mem_address, words_written}, 0);
    check_val("rst_wdata", mem_DataWrite, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_val("init_req", {in_ready, mem_enable, mem_readWrite, mem_address}, {1'b0, 1'b1, MEM_WRITE, ADDR_WR_PTR});
    expect_acc("init_wr", MEM_WRITE, 15'h0002, 32'h0, t);
    wait_ready("init_rdy");

    // 2: single word
    push(32'hDEADBEEF);
    expect_acc("w1_data", MEM_WRITE, 15'h0010, 32'hDEADBEEF, td);
    expect_acc("w1_ptr", MEM_WRITE, 15'h0002, 32'h1, tp);
    wait_ready("w1_rdy");
    check_val("w1_count", words_written, 1);

    // 3: fill to full, poll while stalled, then wrap
    reset_dut();
    expect_acc("init2_wr", MEM_WRITE, 15'h0002, 32'h0, t);
    for (int i = 0; i < 15; i++) begin
      push(32'hA000_0000 + i);
      expect_acc("fill_data", MEM_WRITE, 15'h0010 + 15'(i), 32'hA000_0000 + i, t);
      expect_acc("fill_ptr", MEM_WRITE, 15'h0002, 32'(i + 1), t);
    end
    wait_ready("fill_rdy");
    check_val("fill_count", words_written, 15);
    push(32'hA000_000F);
    expect_acc("poll1", MEM_READ, 15'h0001, 32'h0, t1);
    expect_acc("poll2", MEM_READ, 15'h0001, 32'h0, t2);
    check_val("poll_gap", t2 - t1, 13);
    check_val("full_flag", ring_full, 1);
    expect_acc("poll3", MEM_READ, 15'h0001, 32'h0, t);
    rp_val = 32'h3;
    expect_acc("poll4", MEM_READ, 15'h0001, 32'h3, t);
    expect_acc("wrap_data", MEM_WRITE, 15'h001F, 32'hA000_000F, t);
    expect_acc("wrap_ptr", MEM_WRITE, 15'h0002, 32'h0, t);
    wait_ready("wrap_rdy");
    check_val("wrap_count", words_written, 16);
    check_val("full_clr", ring_full, 0);

    // 4: memory stalls for 50 cycles mid-write
    stall = 1'b1;
    push(32'h5555AAAA);
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      seen = mem_enable;
    end
    check_val("stall_req", seen, 1);
    sig = {mem_readWrite, mem_address, mem_DataWrite};
    changed = 0;
    dropped = 0;
    repeat (50) begin
      @(negedge clk);
      if ({mem_readWrite, mem_address, mem_DataWrite} != sig) changed = 1;
      if (!mem_enable) dropped = 1;
    end
    check_val("stall_sig", {changed, dropped}, 0);
    check_val("stall_nolog", log_q.size(), 0);
    stall = 1'b0;
    expect_acc("stall_data", MEM_WRITE, 15'h0010, 32'h5555AAAA, t);
    expect_acc("stall_ptr", MEM_WRITE, 15'h0002, 32'h1, t);
    wait_ready("stall_rdy");
    repeat (20) @(negedge clk);
    check_val("one_per_done", log_q.size(), 0);
    check_val("stall_count", words_written, 17);

    // 5: reset while the slot write is outstanding
    stall = 1'b1;
    push(32'hC0FFEE00);
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      seen = mem_enable;
    end
    check_val("rst_mid_addr", {seen, mem_address}, {1'b1, 15'h0011});
    @(negedge clk);
    rst = 1'b1;
    #1 check_val("rst_mid_en", mem_enable, 0);
    stall = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    expect_acc("rst_mid_init", MEM_WRITE, 15'h0002, 32'h0, t);
    wait_ready("rst_mid_rdy");
    check_val("rst_mid_count", words_written, 0);

    // 6: in_valid held high with back-to-back words
    for (int i = 0; i < 5; i++) d[i] = 32'hB000_0000 + 32'(i * 17);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d[0];
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 3000 && !in_ready; k++) @(negedge clk);
      @(posedge clk);
      #1;
      if (i < 4) in_data = d[i + 1];
      else in_valid = 1'b0;
    end
    for (int i = 0; i < 5; i++) begin
      expect_acc("b2b_data", MEM_WRITE, 15'h0010 + 15'(i), d[i], td);
      expect_acc("b2b_ptr", MEM_WRITE, 15'h0002, 32'(i + 1), tp);
      check_val("b2b_order", (td < tp), 1);
    end
    wait_ready("b2b_rdy");
    repeat (20) @(negedge clk);
    check_val("b2b_extra", log_q.size(), 0);
    check_val("b2b_count", words_written, 5);

    check_val("protocol", prot_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
